// File: rtl/clk_reset_sequencer.sv
// PLL bring-up and per-domain reset sequencer: pulses the PLL reset, waits for settled lock,
// then releases mem, game and pixel resets in order; retries on lock timeout, faults after MAX_RETRY.
module clk_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 500000,
    parameter int unsigned STAGE_DELAY    = 256,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       pixel_locked,
    input  logic       game_locked,
    input  logic       mem_locked,
    input  logic       soft_restart,
    output logic       pll_rst,
    output logic       mem_rst_n,
    output logic       game_rst_n,
    output logic       pixel_rst_n,
    output logic       sys_ready,
    output logic       fault,
    output logic [2:0] retry_count,
    output logic [2:0] seq_state
);

    localparam int unsigned TW = 20;
    localparam int unsigned RW = 3;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_MEM   = 3'd2,
        ST_REL_GAME  = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [TW-1:0]   settle_q, settle_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [2:0]      sync1_q, sync1_d;
    logic [2:0]      sync2_q, sync2_d;
    logic            pll_rst_q, pll_rst_d;
    logic            mem_rst_n_q, mem_rst_n_d;
    logic            game_rst_n_q, game_rst_n_d;
    logic            pixel_rst_n_q, pixel_rst_n_d;
    logic            sys_ready_q, sys_ready_d;
    logic            fault_q, fault_d;
    logic            lock_all;

    assign lock_all = &sync2_q;

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_PLL_RST;
            timer_q       <= '0;
            settle_q      <= '0;
            retry_q       <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            pll_rst_q     <= 1'b1;
            mem_rst_n_q   <= 1'b0;
            game_rst_n_q  <= 1'b0;
            pixel_rst_n_q <= 1'b0;
            sys_ready_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            settle_q      <= settle_d;
            retry_q       <= retry_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            pll_rst_q     <= pll_rst_d;
            mem_rst_n_q   <= mem_rst_n_d;
            game_rst_n_q  <= game_rst_n_d;
            pixel_rst_n_q <= pixel_rst_n_d;
            sys_ready_q   <= sys_ready_d;
            fault_q       <= fault_d;
        end
    end

    // Next state; soft_restart overrides lock loss, which overrides stage/timeout expiry.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        settle_d = '0;
        retry_d  = retry_q;
        sync1_d  = {pixel_locked, game_locked, mem_locked};
        sync2_d  = sync1_q;

        case (state_q)
            ST_PLL_RST: begin
                if (timer_q == TW'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                settle_d = lock_all ? settle_q + TW'(1) : '0;
                if (lock_all && (settle_q == TW'(STAGE_DELAY - 1))) begin
                    state_d = ST_REL_MEM;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = (retry_d == RW'(MAX_RETRY)) ? ST_FAULT : ST_PLL_RST;
                end
            end
            ST_REL_MEM: begin
                if (!lock_all)                             state_d = ST_WAIT_LOCK;
                else if (timer_q == TW'(STAGE_DELAY - 1)) state_d = ST_REL_GAME;
            end
            ST_REL_GAME: begin
                if (!lock_all) begin
                    state_d = ST_WAIT_LOCK;
                end else if (timer_q == TW'(STAGE_DELAY - 1)) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_all) state_d = ST_WAIT_LOCK;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: state_d = ST_PLL_RST;
        endcase

        if (soft_restart) begin
            state_d = ST_PLL_RST;
            retry_d = '0;
        end

        if (state_d != ST_WAIT_LOCK || soft_restart) settle_d = '0;

        // Timer restarts on any transition (including restart-in-place) and idles in RUN/FAULT.
        if ((state_d != state_q) || soft_restart)          timer_d = '0;
        else if (state_q == ST_RUN || state_q == ST_FAULT) timer_d = timer_q;
        else                                               timer_d = timer_q + TW'(1);

        pll_rst_d     = (state_d == ST_PLL_RST);
        mem_rst_n_d   = (state_d == ST_REL_MEM) || (state_d == ST_REL_GAME) || (state_d == ST_RUN);
        game_rst_n_d  = (state_d == ST_REL_GAME) || (state_d == ST_RUN);
        pixel_rst_n_d = (state_d == ST_RUN);
        sys_ready_d   = (state_d == ST_RUN);
        fault_d       = (state_d == ST_FAULT);
    end

    assign pll_rst     = pll_rst_q;
    assign mem_rst_n   = mem_rst_n_q;
    assign game_rst_n  = game_rst_n_q;
    assign pixel_rst_n = pixel_rst_n_q;
    assign sys_ready   = sys_ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign seq_state   = state_q;

endmodule
